prng_byte_display_buffer: RTL and testbench
===========================================

// Module: prng_byte_display_buffer
// PURPOSE
//  Downstream stage of the PRNG/mux datapath: accepts 8-bit random samples on a
//  valid/ready strobe and buffers them in a small FIFO. Each sample is then
//  presented to the two DEC_7SEG digit decoders for a fixed dwell time, so a
//  fast PRNG stays readable on HEX0/HEX1. Supports pause and single-step for
//  bring-up on the board switches.
// PARAMETERS
//  HOLD_TICKS  24'd10_000_000  CLK cycles each byte is held on disp_byte; must be >= 1
//  DEPTH       4               FIFO entries; must be a power of 2 and >= 2
//  AW          2               log2(DEPTH)
// PORTS
//  CLK           in   1     system clock; all logic is on posedge
//  rst           in   1     asynchronous reset, active-low
//  en            in   1     synchronous enable; low = clear (see below)
//  sample_valid  in   1     producer offers sample_data this cycle
//  sample_data   in   8     PRNG byte (mux output)
//  sample_ready  out  1     FIFO can accept; = (count < DEPTH)
//  pause         in   1     level; freeze the display at dwell expiry
//  step          in   1     level from switch; rising edge advances one byte while paused
//  disp_byte     out  8     byte for the decoders: [3:0] -> HEX0, [7:4] -> HEX1
//  disp_valid    out  1     disp_byte holds a real sample
//  fifo_count    out  AW+1  current FIFO occupancy, 0..DEPTH
//  overflow      out  1     sticky: sample_valid was seen while sample_ready = 0
// BEHAVIOUR
//  Reset (rst = 0, async): FIFO empty, FSM = IDLE, timer = 0, step edge register = 0.
//   All outputs 0 except sample_ready = 1.
//  en = 0 (synchronous, checked every edge): same state as reset. Input pushes are
//   ignored while en = 0.
//  FIFO
//  - Push when sample_valid && sample_ready. sample_ready is derived from the
//    registered count only, so there is no push-through when full, even if a pop
//    happens in the same cycle.
//  - A pop happens only in the LOAD state. There is no bypass when empty: a byte
//    pushed at edge t is first visible to the FSM after edge t.
//  - A push and a pop in the same cycle leave the count unchanged.
//  - Read and write pointers are AW bits wide and wrap modulo DEPTH.
//  - overflow is set when sample_valid && !sample_ready. It is cleared only by rst
//    or en = 0.
//  FSM states
//  - IDLE:   if count != 0 -> LOAD.
//  - LOAD:   one cycle. Pop the head of the FIFO into disp_byte; set disp_valid <= 1;
//            timer <= HOLD_TICKS-1; -> HOLD.
//  - HOLD:   if timer != 0, decrement the timer. If timer == 0:
//            pause = 1 -> PAUSED; else count != 0 -> LOAD; else -> IDLE.
//  - PAUSED: if pause = 0: count != 0 -> LOAD, else -> IDLE.
//            Else, on a step rising edge (step && !step_q) with count != 0 -> LOAD.
//            A step edge with an empty FIFO is dropped.
//  Output rules
//  - disp_byte and disp_valid change only in LOAD, or on reset / en = 0.
//  - The last byte stays displayed in IDLE and PAUSED.
//  - pause asserted in mid-HOLD has no effect until the timer expires.
//  - step is ignored outside PAUSED. step_q is updated every cycle.
//  Latency
//  - Empty FIFO and IDLE, push at edge t: LOAD is entered at edge t+1, and
//    disp_byte updates at edge t+2.
//  - Back-to-back bytes appear every HOLD_TICKS+1 cycles (HOLD cycles plus one LOAD cycle).
//  - HOLD_TICKS = 1 gives HOLD for one cycle, i.e. a new byte every 2 cycles.
//  Widths
//  - timer is 24 bits.
//  - fifo_count is AW+1 bits, so the value DEPTH is representable.
// TESTING (HOLD_TICKS = 4, DEPTH = 4 unless noted)
//  1 Reset/latency: release rst; push 0xA5 at edge t
//    -> disp_byte = 0xA5 and disp_valid = 1 at edge t+2; fifo_count goes 1 -> 0.
//  2 Dwell/order: push 0x11, 0x22, 0x33 on consecutive cycles
//    -> each byte is shown in order; disp_byte changes exactly 5 cycles apart.
//  3 Full/overflow: hold pause = 1 after the first load and push 6 bytes
//    -> fifo_count saturates at 4, sample_ready = 0, overflow = 1 and stays 1;
//       the excess bytes are dropped.
//  4 Pause/step: while PAUSED with 2 bytes queued, give one step rising edge
//    -> exactly one new byte is shown; step held high gives no further advance;
//       a second edge shows the next byte.
//  5 Simultaneous push/pop at count = 4: sample_valid during LOAD -> push refused
//    (ready = 0), count = 3, overflow = 1. At count = 2, push during LOAD -> count stays 2.
//  6 Async reset mid-HOLD, and en = 0 mid-HOLD -> all outputs 0 and sample_ready = 1
//    (async: immediately; en: next edge); FIFO contents discarded; first push
//    afterwards shows after 2 edges.

Source files
------------

// File: rtl/prng_byte_display_buffer_if.sv
// Sample/display bus between the PRNG datapath, the board switches and the
// 7-segment display buffer.
//   en, sample_valid, sample_data, pause, step : producer/switch side -> buffer
//   sample_ready, disp_byte, disp_valid,
//   fifo_count, overflow                      : buffer -> producer/decoders
interface prng_byte_display_buffer_if #(
    parameter int unsigned AW = 2
);
    logic          en;
    logic          sample_valid;
    logic [7:0]    sample_data;
    logic          sample_ready;
    logic          pause;
    logic          step;
    logic [7:0]    disp_byte;
    logic          disp_valid;
    logic [AW:0]   fifo_count;
    logic          overflow;

    // Producer / switch side
    modport master (
        output en, sample_valid, sample_data, pause, step,
        input  sample_ready, disp_byte, disp_valid, fifo_count, overflow
    );

    // Display buffer side
    modport slave (
        input  en, sample_valid, sample_data, pause, step,
        output sample_ready, disp_byte, disp_valid, fifo_count, overflow
    );
endinterface

// File: rtl/prng_byte_display_buffer.sv
// Buffers PRNG bytes in a small FIFO and shows each one on disp_byte for
// HOLD_TICKS cycles so the HEX0/HEX1 digits stay readable; pause freezes the
// display at dwell expiry and a step rising edge advances one byte while paused.
// Ports:
//   CLK  : clock, posedge
//   rst  : asynchronous reset, active-low
//   bus  : slave modport; en (sync clear when low), sample_valid/data/ready,
//          pause, step, disp_byte, disp_valid, fifo_count, overflow (sticky)
module prng_byte_display_buffer #(
    parameter logic [23:0] HOLD_TICKS = 24'd10_000_000,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AW         = 2
) (
    input  logic                          CLK,
    input  logic                          rst,
    prng_byte_display_buffer_if.slave     bus
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        HOLD   = 2'd2,
        PAUSED = 2'd3
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          ready_q;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic          step_rise;

    state_t        state;
    logic [23:0]   timer;
    logic [7:0]    disp_byte_q;
    logic          disp_valid_q;
    logic          step_q;

    // Push/pop decode and next occupancy
    always_comb begin
        push      = bus.sample_valid && ready_q;
        pop       = (state == LOAD);
        count_nxt = count + CW'(push) - CW'(pop);
        not_empty = (count != '0);
        step_rise = bus.step && !step_q;
    end

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge CLK) begin
        if (bus.en && push) begin
            mem[wr_ptr] <= bus.sample_data;
        end
    end

    // Pointers, occupancy, registered ready (from next count) and sticky overflow
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else if (!bus.en) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nxt;
            ready_q <= (count_nxt < CW'(DEPTH));
            if (bus.sample_valid && !ready_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Display FSM: LOAD pops one byte, HOLD dwells, PAUSED waits for release/step
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            disp_byte_q  <= '0;
            disp_valid_q <= 1'b0;
            step_q       <= 1'b0;
        end else if (!bus.en) begin
            state        <= IDLE;
            timer        <= '0;
            disp_byte_q  <= '0;
            disp_valid_q <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            step_q <= bus.step;
            case (state)
                IDLE: begin
                    if (not_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    disp_byte_q  <= mem[rd_ptr];
                    disp_valid_q <= 1'b1;
                    timer        <= HOLD_TICKS - 24'd1;
                    state        <= HOLD;
                end
                HOLD: begin
                    // pause is only looked at once the dwell has expired
                    if (timer != '0) begin
                        timer <= timer - 24'd1;
                    end else if (bus.pause) begin
                        state <= PAUSED;
                    end else if (not_empty) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                PAUSED: begin
                    // a step edge with nothing queued is simply dropped
                    if (!bus.pause) begin
                        state <= not_empty ? LOAD : IDLE;
                    end else if (step_rise && not_empty) begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.overflow     = ovf_q;
    assign bus.fifo_count   = count;
    assign bus.disp_byte    = disp_byte_q;
    assign bus.disp_valid   = disp_valid_q;

endmodule

// File: tb/tb_prng_byte_display_buffer.sv
// Directed bench for prng_byte_display_buffer with HOLD_TICKS = 4, DEPTH = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_prng_byte_display_buffer;

    logic CLK;
    logic rst;
    int   checks;
    int   errors;

    prng_byte_display_buffer_if #(.AW(2)) bus ();

    prng_byte_display_buffer #(
        .HOLD_TICKS (24'd4),
        .DEPTH      (4),
        .AW         (2)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs expected in the reset / cleared state
    task automatic chk_clear(input string tag);
        chk({tag, ".disp_byte"},  32'(bus.disp_byte),  32'h00);
        chk({tag, ".disp_valid"}, 32'(bus.disp_valid), 32'd0);
        chk({tag, ".count"},      32'(bus.fifo_count), 32'd0);
        chk({tag, ".ready"},      32'(bus.sample_ready), 32'd1);
        chk({tag, ".overflow"},   32'(bus.overflow),   32'd0);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        bus.en           = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 8'h00;
        bus.pause        = 1'b0;
        bus.step         = 1'b0;

        // 1: reset state and first-byte latency
        ticks(2);
        chk_clear("reset");
        rst = 1'b1;
        tick();
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'hA5;
        tick();                                   // edge t: push
        bus.sample_valid = 1'b0;
        chk("lat.count_t",  32'(bus.fifo_count), 32'd1);
        chk("lat.valid_t",  32'(bus.disp_valid), 32'd0);
        tick();                                   // t+1: enter LOAD
        chk("lat.valid_t1", 32'(bus.disp_valid), 32'd0);
        tick();                                   // t+2: byte shown
        chk("lat.byte_t2",  32'(bus.disp_byte),  32'hA5);
        chk("lat.valid_t2", 32'(bus.disp_valid), 32'd1);
        chk("lat.count_t2", 32'(bus.fifo_count), 32'd0);
        ticks(6);
        chk("idle.keep",    32'(bus.disp_byte),  32'hA5);

        // 2: dwell and ordering, bytes change every 5 cycles
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'h11;
        tick();                                   // e
        bus.sample_data  = 8'h22;
        tick();                                   // e+1
        bus.sample_data  = 8'h33;
        tick();                                   // e+2: 0x11 shown
        bus.sample_valid = 1'b0;
        chk("dwell.b11",    32'(bus.disp_byte),  32'h11);
        chk("dwell.cnt2",   32'(bus.fifo_count), 32'd2);
        ticks(4);                                 // e+6
        chk("dwell.b11_end", 32'(bus.disp_byte), 32'h11);
        tick();                                   // e+7
        chk("dwell.b22",    32'(bus.disp_byte),  32'h22);
        ticks(4);                                 // e+11
        chk("dwell.b22_end", 32'(bus.disp_byte), 32'h22);
        tick();                                   // e+12
        chk("dwell.b33",    32'(bus.disp_byte),  32'h33);
        chk("dwell.cnt0",   32'(bus.fifo_count), 32'd0);
        ticks(5);

        // 3: fill while paused, overflow on the sixth byte
        bus.pause        = 1'b1;
        bus.sample_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.sample_data = 8'(i);
            tick();                               // f .. f+5
        end
        bus.sample_valid = 1'b0;
        chk("full.count",   32'(bus.fifo_count), 32'd4);
        chk("full.ready",   32'(bus.sample_ready), 32'd0);
        chk("full.ovf",     32'(bus.overflow),   32'd1);
        chk("full.byte",    32'(bus.disp_byte),  32'h01);
        ticks(5);                                 // parked in PAUSED
        chk("paused.byte",  32'(bus.disp_byte),  32'h01);
        chk("paused.count", 32'(bus.fifo_count), 32'd4);
        chk("paused.ovf",   32'(bus.overflow),   32'd1);

        // 4/5: step edge at count 4, push refused during the LOAD
        bus.step = 1'b1;
        tick();                                   // g: step edge -> LOAD
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'hEE;
        tick();                                   // g+1
        bus.sample_valid = 1'b0;
        chk("step1.byte",   32'(bus.disp_byte),  32'h02);
        chk("step1.count",  32'(bus.fifo_count), 32'd3);
        chk("step1.ready",  32'(bus.sample_ready), 32'd1);
        chk("step1.ovf",    32'(bus.overflow),   32'd1);
        ticks(9);                                 // step still high
        chk("stephold.byte", 32'(bus.disp_byte), 32'h02);
        chk("stephold.cnt", 32'(bus.fifo_count), 32'd3);
        bus.step = 1'b0;
        tick();
        bus.step = 1'b1;
        tick();                                   // h: LOAD
        chk("step2.before", 32'(bus.disp_byte),  32'h02);
        tick();                                   // h+1
        chk("step2.byte",   32'(bus.disp_byte),  32'h03);
        chk("step2.count",  32'(bus.fifo_count), 32'd2);
        ticks(4);
        bus.step = 1'b0;
        tick();
        bus.step = 1'b1;
        tick();                                   // k: LOAD
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'h77;
        tick();                                   // k+1: pop and push together
        bus.sample_valid = 1'b0;
        chk("pushpop.byte",  32'(bus.disp_byte),  32'h04);
        chk("pushpop.count", 32'(bus.fifo_count), 32'd2);

        // release pause: queue drains at the normal dwell rate
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        ticks(4);                                 // k+5
        chk("resume.before", 32'(bus.disp_byte), 32'h04);
        tick();                                   // k+6
        chk("resume.byte",  32'(bus.disp_byte),  32'h05);
        chk("resume.count", 32'(bus.fifo_count), 32'd1);
        tick();

        // 6: async reset mid-HOLD discards the queued 0x77 and clears overflow
        rst = 1'b0;
        #1;
        chk_clear("arst");
        tick();
        rst = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'h5A;
        tick();                                   // r
        bus.sample_valid = 1'b0;
        tick();                                   // r+1
        chk("arst.pre",     32'(bus.disp_valid), 32'd0);
        tick();                                   // r+2
        chk("arst.byte",    32'(bus.disp_byte),  32'h5A);
        chk("arst.count",   32'(bus.fifo_count), 32'd0);

        // en = 0 mid-HOLD: takes effect only at the next edge
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'h99;
        tick();                                   // r+3
        bus.sample_valid = 1'b0;
        bus.en = 1'b0;
        #1;
        chk("en.sync_byte", 32'(bus.disp_byte),  32'h5A);
        chk("en.sync_cnt",  32'(bus.fifo_count), 32'd1);
        tick();
        chk_clear("en");
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'hC3;
        tick();                                   // push ignored while disabled
        bus.sample_valid = 1'b0;
        chk("en.nopush",    32'(bus.fifo_count), 32'd0);
        bus.en = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'h3C;
        tick();                                   // s
        bus.sample_valid = 1'b0;
        tick();                                   // s+1
        chk("en.pre",       32'(bus.disp_valid), 32'd0);
        tick();                                   // s+2
        chk("en.byte",      32'(bus.disp_byte),  32'h3C);
        chk("en.valid",     32'(bus.disp_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
